// File: rtl/apb_write_master.sv
// APB write requester: buffers write commands in a small FIFO and issues each
// as an APB SETUP/ACCESS transfer, aborting transfers stuck in wait states.
module apb_write_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [31:0]                   cmd_addr,
    input  logic [31:0]                   cmd_data,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [31:0]                   PADDR,
    output logic [31:0]                   PWDATA,
    input  logic                          PREADY,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   wr_count
);

    // state  | meaning
    // IDLE   | bus idle, waiting for a queued command
    // SETUP  | first APB cycle: PSEL=1, PENABLE=0
    // ACCESS | PENABLE=1, waiting on PREADY or the wait-state timeout

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state;
    logic [63:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [63:0]   head;
    logic          push;
    logic          pop;
    logic [TW-1:0] tmo_cnt;

    assign cmd_ready  = (count != FULL_LVL);
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (count != '0) || (state != IDLE);

    always_comb begin
        pop = 1'b0;
        if (count != '0) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (state == ACCESS && PREADY) begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Timeout is a down-counter reloaded on every SETUP; terminal count 0 aborts.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            wr_count    <= '0;
            tmo_cnt     <= '0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        PADDR   <= head[63:32] & 32'hFFFF_FFFC;
                        PWDATA  <= head[31:0];
                        PSEL    <= 1'b1;
                        PWRITE  <= 1'b1;
                        PENABLE <= 1'b0;
                        tmo_cnt <= TMO_LOAD;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        done     <= 1'b1;
                        wr_count <= wr_count + 1'b1;
                        if (pop) begin
                            PADDR   <= head[63:32] & 32'hFFFF_FFFC;
                            PWDATA  <= head[31:0];
                            PENABLE <= 1'b0;
                            tmo_cnt <= TMO_LOAD;
                            state   <= SETUP;
                        end else begin
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                            PWRITE  <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (TIMEOUT > 0 && tmo_cnt == '0) begin
                        timeout_err <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        PWRITE      <= 1'b0;
                        state       <= IDLE;
                    end else if (TIMEOUT > 0) begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    PWRITE  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_write_master.sv
// Bench for apb_write_master: transaction-level model with per-cycle compare,
// directed latency/boundary cases and a randomized soak.
module tb_apb_write_master;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        pready = 1'b0;

    logic        cmd_ready;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [2:0]  fifo_count;
    logic [15:0] wr_count;

    apb_write_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .PCLK        (clk),
        .PRESETn     (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .PSEL        (psel),
        .PENABLE     (penable),
        .PWRITE      (pwrite),
        .PADDR       (paddr),
        .PWDATA      (pwdata),
        .PREADY      (pready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .fifo_count  (fifo_count),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Simple slave memory observing completed writes.
    logic [31:0] slave_mem [256];
    always @(posedge clk) begin
        if (psel && penable && pready) slave_mem[paddr[9:2]] <= pwdata;
    end

    // Transaction-level model: a command queue plus the one transfer on the bus.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    cmd_t        q[$];
    bit          m_active;
    bit          m_access;
    int          m_waits;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [15:0] m_wr;
    bit          m_done;
    bit          m_terr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t: wait budget expired", nm, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0;
        m_access = 0;
        m_waits  = 0;
        m_addr   = '0;
        m_data   = '0;
        m_wr     = '0;
        m_done   = 0;
        m_terr   = 0;
    endtask

    task automatic model_start(input cmd_t c);
        m_addr   = c.a & 32'hFFFF_FFFC;
        m_data   = c.d;
        m_active = 1;
        m_access = 0;
    endtask

    // One clock edge of the model, using the inputs presented at that edge.
    task automatic model_edge();
        bit   take;
        cmd_t c;
        take   = cmd_valid && (q.size() < DEPTH);
        m_done = 0;
        m_terr = 0;
        if (!m_active) begin
            if (q.size() > 0) begin
                c = q.pop_front();
                model_start(c);
            end
        end else if (!m_access) begin
            m_access = 1;
            m_waits  = 0;
        end else if (pready) begin
            m_done = 1;
            m_wr   = m_wr + 16'd1;
            if (q.size() > 0) begin
                c = q.pop_front();
                model_start(c);
            end else begin
                m_active = 0;
                m_access = 0;
            end
        end else begin
            m_waits++;
            if (TMO > 0 && m_waits == TMO) begin
                m_terr   = 1;
                m_active = 0;
                m_access = 0;
            end
        end
        if (take) begin
            c.a = cmd_addr;
            c.d = cmd_data;
            q.push_back(c);
        end
    endtask

    task automatic check_model();
        chk("psel", psel, m_active);
        chk("penable", penable, m_active && m_access);
        chk("pwrite", pwrite, m_active);
        chk("paddr", paddr, m_addr);
        chk("pwdata", pwdata, m_data);
        chk("done", done, m_done);
        chk("timeout_err", timeout_err, m_terr);
        chk("wr_count", wr_count, m_wr);
        chk("fifo_count", fifo_count, q.size());
        chk("cmd_ready", cmd_ready, q.size() < DEPTH);
        chk("busy", busy, (q.size() > 0) || m_active);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int acc;
        int dones;
        int gaps;
        int cyc;
        int i;
        int mode;
        bit seen;
        bit stable;
        bit terr_seen;
        bit saw_full;
        bit acc_now;

        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        chk("rst_psel", psel, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_count", wr_count, 0);
        rst_n = 1'b1;

        // Single write, zero wait states.
        cmd_valid = 1; cmd_addr = 32'h10; cmd_data = 32'hDEADBEEF; pready = 1;
        tick();
        cmd_valid = 0;
        chk("t1_queued", fifo_count, 1);
        chk("t1_psel_e0", psel, 0);
        tick();
        chk("t1_psel_e1", psel, 1);
        chk("t1_penable_e1", penable, 0);
        chk("t1_paddr", paddr, 32'h10);
        tick();
        chk("t1_penable_e2", penable, 1);
        tick();
        chk("t1_done_e3", done, 1);
        chk("t1_wr_count", wr_count, 1);
        chk("t1_psel_e3", psel, 0);
        tick();
        chk("t1_done_clear", done, 0);

        // Two wait states.
        cmd_valid = 1; cmd_addr = 32'h04; cmd_data = 32'h12345678; pready = 0;
        tick();
        cmd_valid = 0;
        acc = 0; dones = 0; seen = 0; stable = 1;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (penable) begin
                acc++;
                if (paddr !== 32'h04 || pwdata !== 32'h12345678) stable = 0;
            end
            if (done) begin
                dones++;
                seen = 1;
            end
            pready = (acc >= 3);
        end
        if (!seen) bound_fail("t2_done_wait");
        pready = 1;
        repeat (2) begin
            tick();
            if (done) dones++;
        end
        chk("t2_access_cycles", acc, 3);
        chk("t2_stable", stable, 1);
        chk("t2_done_pulses", dones, 1);
        chk("t2_slave_mem1", slave_mem[1], 32'h12345678);
        chk("t2_wr_count", wr_count, 2);

        // PREADY arrives exactly on the edge that would otherwise time out.
        cmd_valid = 1; cmd_addr = 32'h20; cmd_data = 32'h0BAD_F00D; pready = 0;
        tick();
        cmd_valid = 0;
        acc = 0; seen = 0; terr_seen = 0;
        for (int n = 0; n < 40 && !seen && !terr_seen; n++) begin
            tick();
            if (penable) acc++;
            if (done) seen = 1;
            if (timeout_err) terr_seen = 1;
            pready = (acc >= TMO);
        end
        chk("bnd_done", seen, 1);
        chk("bnd_no_timeout", terr_seen, 0);
        chk("bnd_access_cycles", acc, TMO);
        chk("bnd_wr_count", wr_count, 3);

        // Timeout with a second command queued behind.
        pready = 0;
        cmd_valid = 1; cmd_addr = 32'h30; cmd_data = 32'hA0A0_A0A0;
        tick();
        cmd_addr = 32'h34; cmd_data = 32'hB1B1_B1B1;
        tick();
        cmd_valid = 0;
        acc = 0; terr_seen = 0;
        for (int n = 0; n < 60 && !terr_seen; n++) begin
            tick();
            if (penable) acc++;
            if (timeout_err) terr_seen = 1;
        end
        if (!terr_seen) bound_fail("tmo_wait");
        chk("tmo_access_cycles", acc, TMO);
        chk("tmo_psel", psel, 0);
        chk("tmo_wr_count", wr_count, 3);
        pready = 1;
        tick();
        chk("tmo_next_psel", psel, 1);
        chk("tmo_next_paddr", paddr, 32'h34);
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (done) seen = 1;
        end
        if (!seen) bound_fail("tmo_next_done");
        chk("tmo_next_wr_count", wr_count, 4);
        chk("tmo_slave_mem", slave_mem[13], 32'hB1B1_B1B1);

        // Burst of six pushes into a four-entry FIFO.
        i = 0; cyc = 0; saw_full = 0;
        while (i < 6 && cyc < 40) begin
            cmd_valid = 1;
            cmd_addr  = 32'h100 + i * 4;
            cmd_data  = 32'hB000_0000 + i;
            pready    = (cyc >= 6);
            acc_now   = cmd_ready;
            tick();
            cyc++;
            if (acc_now) i++;
            if (fifo_count == 3'd4 && !cmd_ready) saw_full = 1;
        end
        if (i < 6) bound_fail("burst_push");
        cmd_valid = 0; pready = 1;
        gaps = 0; seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick();
            if (busy && !psel) gaps++;
            if (!busy) seen = 1;
        end
        if (!seen) bound_fail("burst_drain");
        chk("burst_saw_full", saw_full, 1);
        chk("burst_psel_gaps", gaps, 0);
        chk("burst_wr_count", wr_count, 10);
        for (int k = 0; k < 6; k++) chk("burst_slave_mem", slave_mem[64 + k], 32'hB000_0000 + k);

        // Unaligned address.
        cmd_valid = 1; cmd_addr = 32'h0000_0107; cmd_data = 32'hCAFE_0107; pready = 1;
        tick();
        cmd_valid = 0;
        tick();
        chk("unal_psel", psel, 1);
        chk("unal_paddr", paddr, 32'h0000_0104);
        repeat (3) tick();
        chk("unal_wr_count", wr_count, 11);

        // Reset in the middle of ACCESS with two entries queued.
        pready = 0; cmd_valid = 1;
        for (int k = 0; k < 3; k++) begin
            cmd_addr = 32'h200 + k * 4;
            cmd_data = 32'h5500_0000 + k;
            tick();
        end
        cmd_valid = 0;
        chk("rm_penable_before", penable, 1);
        chk("rm_fifo_before", fifo_count, 2);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("rm_psel", psel, 0);
        chk("rm_penable", penable, 0);
        chk("rm_fifo_count", fifo_count, 0);
        chk("rm_wr_count", wr_count, 0);
        check_model();
        @(negedge clk);
        chk("rm_no_done", done, 0);
        chk("rm_no_timeout", timeout_err, 0);
        rst_n = 1;
        cmd_valid = 1; cmd_addr = 32'h300; cmd_data = 32'h7777_1234; pready = 1;
        tick();
        cmd_valid = 0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (done) seen = 1;
        end
        if (!seen) bound_fail("rm_after_done");
        chk("rm_after_wr_count", wr_count, 1);
        chk("rm_after_slave", slave_mem[192], 32'h7777_1234);

        // Randomized soak with varying slave behaviour.
        mode = 0;
        for (int n = 0; n < 1500; n++) begin
            if (n % 50 == 0) mode = $urandom_range(0, 2);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_addr  = $urandom;
            cmd_data  = $urandom;
            case (mode)
                0:       pready = ($urandom_range(0, 9) < 8);
                1:       pready = ($urandom_range(0, 9) < 3);
                default: pready = 0;
            endcase
            tick();
        end
        cmd_valid = 0; pready = 1;
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            tick();
            if (!busy) seen = 1;
        end
        if (!seen) bound_fail("soak_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
